// File: rtl/sc_point_register_bank.sv
// sc_point_register_bank
//   Datapath end of the point (frog) command interface. Executes clear, up (load0),
//   down (load1) and left/right (shiftselection) commands from the point state machine
//   and holds the frog position as a one-hot row/column matrix. Entering the goal row
//   scores a point and sends the frog back to the start square.
//
// Ports
//   SC_STATEMACHINEPOINT_CLOCK_50      in   system clock, rising edge
//   SC_STATEMACHINEPOINT_RESET_InHigh  in   asynchronous reset, active-high
//   clear_InLow                        in   0 = restart game (position + score)
//   load0_InLow                        in   0 = move up one row
//   load1_InLow                        in   0 = move down one row
//   shiftselection_In [1:0]            in   01 = left, 10 = right, 00/11 = hold
//   matrix_Out                         out  row r at [r*DATAWIDTH_BUS +: DATAWIDTH_BUS]
//   rowIndex_Out                       out  current row
//   FirstRegister_OutLow               out  0 = frog in row 0
//   goal_OutHigh                       out  one-cycle pulse on a goal
//   score_Out                          out  goals since clear, saturating
//
// Build option
//   SC_POINT_WRAP_EN: when defined, left/right wrap around the row edges instead of
//   saturating.
module sc_point_register_bank #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned ROWS          = 8,
  parameter int unsigned START_COLUMN  = 3,
  parameter int unsigned SCORE_WIDTH   = 4,
  localparam int unsigned RowW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                          SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                          SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                          clear_InLow,
  input  logic                          load0_InLow,
  input  logic                          load1_InLow,
  input  logic [1:0]                    shiftselection_In,
  output logic [ROWS*DATAWIDTH_BUS-1:0] matrix_Out,
  output logic [RowW-1:0]               rowIndex_Out,
  output logic                          FirstRegister_OutLow,
  output logic                          goal_OutHigh,
  output logic [SCORE_WIDTH-1:0]        score_Out
);

  localparam logic [DATAWIDTH_BUS-1:0] StartMask = DATAWIDTH_BUS'(1) << START_COLUMN;
  // Last row the frog can stand on; a move up from here is a goal.
  localparam logic [RowW-1:0]          PreGoalRow = RowW'(ROWS - 2);

  logic [RowW-1:0]          row_q, row_d;
  logic [DATAWIDTH_BUS-1:0] colMask_q, colMask_d;
  logic [SCORE_WIDTH-1:0]   score_q, score_d;
  logic                     goal_q, goal_d;

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or
              posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      row_q     <= '0;
      colMask_q <= StartMask;
      score_q   <= '0;
      goal_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      colMask_q <= colMask_d;
      score_q   <= score_d;
      goal_q    <= goal_d;
    end
  end

  // Priority: clear > up > down > shift; only one command acts per cycle.
  always_comb begin
    row_d     = row_q;
    colMask_d = colMask_q;
    score_d   = score_q;
    goal_d    = 1'b0;
    if (!clear_InLow) begin
      row_d     = '0;
      colMask_d = StartMask;
      score_d   = '0;
    end else if (!load0_InLow) begin
      if (row_q >= PreGoalRow) begin
        row_d     = '0;
        colMask_d = StartMask;
        goal_d    = 1'b1;
        if (score_q != '1) begin
          score_d = score_q + 1'b1;
        end
      end else begin
        row_d = row_q + 1'b1;
      end
    end else if (!load1_InLow) begin
      if (row_q != '0) begin
        row_d = row_q - 1'b1;
      end
    end else begin
      unique case (shiftselection_In)
        2'b01: begin
`ifdef SC_POINT_WRAP_EN
          colMask_d = {colMask_q[DATAWIDTH_BUS-2:0], colMask_q[DATAWIDTH_BUS-1]};
`else
          if (!colMask_q[DATAWIDTH_BUS-1]) begin
            colMask_d = colMask_q << 1;
          end
`endif
        end
        2'b10: begin
`ifdef SC_POINT_WRAP_EN
          colMask_d = {colMask_q[0], colMask_q[DATAWIDTH_BUS-1:1]};
`else
          if (!colMask_q[0]) begin
            colMask_d = colMask_q >> 1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    matrix_Out = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (row_q == RowW'(r)) begin
        matrix_Out[r*DATAWIDTH_BUS +: DATAWIDTH_BUS] = colMask_q;
      end
    end
  end

  assign rowIndex_Out         = row_q;
  assign FirstRegister_OutLow = (row_q != '0);
  assign goal_OutHigh         = goal_q;
  assign score_Out            = score_q;

endmodule

// File: tb/tb_sc_point_register_bank.sv
module tb_sc_point_register_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1, ld0 = 1'b1, ld1 = 1'b1;
  logic [1:0]  sh = 2'b00;
  logic [63:0] mat;
  logic [2:0]  rowIdx;
  logic        first, goal;
  logic [3:0]  score;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [63:0] mat;
    logic [2:0]  row;
    logic        first;
    logic        goal;
    logic [3:0]  score;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int         mRow   = 0;
  logic [7:0] mCol   = 8'h08;
  int         mScore = 0;

  always #5 clk = ~clk;

  sc_point_register_bank #(
    .DATAWIDTH_BUS(8),
    .ROWS(8),
    .START_COLUMN(3),
    .SCORE_WIDTH(4)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50(clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
    .clear_InLow(clr),
    .load0_InLow(ld0),
    .load1_InLow(ld1),
    .shiftselection_In(sh),
    .matrix_Out(mat),
    .rowIndex_Out(rowIdx),
    .FirstRegister_OutLow(first),
    .goal_OutHigh(goal),
    .score_Out(score)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_exp(input string tag, input logic g);
    exp_t e;
    e.tag   = tag;
    e.mat   = 64'(mCol) << (mRow * 8);
    e.row   = 3'(mRow);
    e.first = (mRow != 0);
    e.goal  = g;
    e.score = 4'(mScore);
    return e;
  endfunction

  task automatic check_outputs(input exp_t e);
    chk({e.tag, ".matrix"}, mat, e.mat);
    chk({e.tag, ".row"}, 64'(rowIdx), 64'(e.row));
    chk({e.tag, ".first"}, 64'(first), 64'(e.first));
    chk({e.tag, ".goal"}, 64'(goal), 64'(e.goal));
    chk({e.tag, ".score"}, 64'(score), 64'(e.score));
  endtask

  // Drive one command for one clock, push the model's prediction, compare after the edge.
  task automatic step(input logic c, input logic l0, input logic l1, input logic [1:0] s,
                      input string tag);
    logic g;
    exp_t e;
    clr = c; ld0 = l0; ld1 = l1; sh = s;
    g = 1'b0;
    if (!c) begin
      mRow = 0; mCol = 8'h08; mScore = 0;
    end else if (!l0) begin
      if (mRow == 6) begin
        mRow = 0; mCol = 8'h08; g = 1'b1;
        if (mScore < 15) mScore++;
      end else mRow++;
    end else if (!l1) begin
      if (mRow > 0) mRow--;
    end else if (s == 2'b01) begin
`ifdef SC_POINT_WRAP_EN
      mCol = (mCol == 8'h80) ? 8'h01 : (mCol << 1);
`else
      mCol = (mCol == 8'h80) ? 8'h80 : (mCol << 1);
`endif
    end else if (s == 2'b10) begin
`ifdef SC_POINT_WRAP_EN
      mCol = (mCol == 8'h01) ? 8'h80 : (mCol >> 1);
`else
      mCol = (mCol == 8'h01) ? 8'h01 : (mCol >> 1);
`endif
    end
    sb.push_back(model_exp(tag, g));
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
    clr = 1'b1; ld0 = 1'b1; ld1 = 1'b1; sh = 2'b00;
  endtask

  task automatic idle(input string tag);
    step(1'b1, 1'b1, 1'b1, 2'b00, tag);
  endtask

  task automatic up(input string tag);
    step(1'b1, 1'b0, 1'b1, 2'b00, tag);
  endtask

  initial begin
    // 1. Reset values, then release with no commands
    #12;
    check_outputs('{"reset", 64'h08, 3'd0, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle("idle_after_reset");

    // 2. Up three rows, left twice
    for (int i = 0; i < 3; i++) up("up3");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 2'b01, "left2");
    chk("row3_slice", 64'(mat[24 +: 8]), 64'h20);
    step(1'b1, 1'b1, 1'b1, 2'b11, "hold11");

    // Down one, down at row 0 held
    step(1'b1, 1'b1, 1'b0, 2'b00, "down");
    step(1'b1, 1'b1, 1'b0, 2'b01, "down_beats_shift");
    step(1'b1, 1'b1, 1'b0, 2'b00, "down_to0");
    step(1'b1, 1'b1, 1'b0, 2'b00, "down_at0_hold");

    // 3. Goal from row 6, pulse lasts one cycle
    for (int i = 0; i < 6; i++) up("up_to6");
    step(1'b1, 1'b0, 1'b0, 2'b01, "goal");
    idle("goal_pulse_end");

    // 4. clear beats load0
    up("pre_clear_up");
    up("pre_clear_up");
    step(1'b0, 1'b0, 1'b1, 2'b00, "clear_vs_up");

    // 5. Edge behaviour
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 2'b01, "left_edge");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 2'b10, "right_edge");
    step(1'b1, 1'b1, 1'b1, 2'b01, "left_from_lsb");

    // 6. Sixteen goals saturate the score at 15
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < 7; i++) up("goal_run");
    end
    idle("score_sat");

    // Reset mid-command at row 4 takes effect without a clock edge
    for (int i = 0; i < 4; i++) up("up_to4");
    ld0 = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    mRow = 0; mCol = 8'h08; mScore = 0;
    check_outputs('{"async_reset", 64'h08, 3'd0, 1'b0, 1'b0, 4'd0});
    @(posedge clk);
    #1;
    check_outputs('{"reset_held", 64'h08, 3'd0, 1'b0, 1'b0, 4'd0});
    ld0 = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    up("after_reset_up");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
